rs_fifo: RTL and testbench

- Parametrised synchronous FIFO; successor to the fixed 8-bit serial-port buffer between the processor and the RS232 path.
- Adds a real full flag, so the processor's fifofull input is no longer tied low.
- Adds a fill level, sticky overflow/underflow error flags and a synchronous flush.
- Single clock domain; instantiated on the board top next to the processor.

---
 rtl/rs_fifo.sv | 123 ++++++++++++
 tb/tb_rs_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rs_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs_fifo : parametrised synchronous FIFO for the processor/RS232 path     |
// | with full flag, fill level, sticky errors and synchronous flush.         |
// | Optional: RS_FIFO_SHOWAHEAD_EN selects zero-latency show-ahead reads.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rs_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              wrreq,
  input  logic              rdreq,
  input  logic              clear,
  output logic [DATA_W-1:0] q,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow
);

  localparam int              c_depth_int = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_depth     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_cnt_one   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [c_depth_int];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_usedw;
  logic              r_empty;
  logic              r_full;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_wr_drop;
  logic              w_rd_drop;
  logic [ADDR_W:0]   w_usedw_nxt;

  // A write into a full FIFO is still accepted when the same cycle pops a word.
  always_comb begin
    w_rd_acc  = rdreq & ~r_empty;
    w_wr_acc  = wrreq & (~r_full | w_rd_acc);
    w_wr_drop = wrreq & ~w_wr_acc;
    w_rd_drop = rdreq & r_empty;
    w_usedw_nxt = r_usedw;
    if (clear) begin
      w_usedw_nxt = '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_usedw_nxt = r_usedw + c_cnt_one;
        2'b01:   w_usedw_nxt = r_usedw - c_cnt_one;
        default: w_usedw_nxt = r_usedw;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_depth_int; i++) r_mem[i] <= '0;
    end else if (w_wr_acc && !clear) begin
      r_mem[r_wptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_usedw     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_usedw <= w_usedw_nxt;
      r_empty <= (w_usedw_nxt == '0);
      r_full  <= (w_usedw_nxt == c_depth);
      if (clear) begin
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        if (w_wr_acc)  r_wptr      <= r_wptr + c_ptr_one;
        if (w_rd_acc)  r_rptr      <= r_rptr + c_ptr_one;
        if (w_wr_drop) r_overflow  <= 1'b1;
        if (w_rd_drop) r_underflow <= 1'b1;
      end
    end
  end

`ifdef RS_FIFO_SHOWAHEAD_EN
  // Head word is presented directly; when empty it shows a stale but stable slot.
  assign q = r_mem[r_rptr];
`else
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (w_rd_acc && !clear) begin
      r_q <= r_mem[r_rptr];
    end
  end

  assign q = r_q;
`endif

  assign empty     = r_empty;
  assign full      = r_full;
  assign usedw     = r_usedw;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_rs_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rs_fifo : directed self-checking bench for rs_fifo (DEPTH=4).         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rs_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] data;
  logic              wrreq;
  logic              rdreq;
  logic              clear;
  logic [DATA_W-1:0] q;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   usedw;
  logic              overflow;
  logic              underflow;

  int checks;
  int failures;

  rs_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .wrreq     (wrreq),
    .rdreq     (rdreq),
    .clear     (clear),
    .q         (q),
    .empty     (empty),
    .full      (full),
    .usedw     (usedw),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request pattern; outputs are sampled 1ns after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    wrreq = w;
    rdreq = r;
    data  = d;
    clear = c;
    @(posedge clk);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    clear = 1'b0;
  endtask

  task automatic fill4;
    step(1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b0, 8'h33, 1'b0);
    step(1'b1, 1'b0, 8'h44, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    data  = '0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_q", 16'(q), 16'h00);
    chk("rst_empty", 16'(empty), 16'h1);
    chk("rst_full", 16'(full), 16'h0);
    chk("rst_usedw", 16'(usedw), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);
    chk("rst_unf", 16'(underflow), 16'h0);

    // 1: fill and drain
    step(1'b1, 1'b0, 8'h11, 1'b0);
    chk("t1_usedw1", 16'(usedw), 16'h1);
    chk("t1_empty0", 16'(empty), 16'h0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    chk("t1_usedw2", 16'(usedw), 16'h2);
    step(1'b1, 1'b0, 8'h33, 1'b0);
    chk("t1_usedw3", 16'(usedw), 16'h3);
    chk("t1_full_at3", 16'(full), 16'h0);
    step(1'b1, 1'b0, 8'h44, 1'b0);
    chk("t1_usedw4", 16'(usedw), 16'h4);
    chk("t1_full", 16'(full), 16'h1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t1_q11", 16'(q), 16'h11);
    chk("t1_usedw_r1", 16'(usedw), 16'h3);
    chk("t1_full_r1", 16'(full), 16'h0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t1_q22", 16'(q), 16'h22);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t1_q33", 16'(q), 16'h33);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t1_q44", 16'(q), 16'h44);
    chk("t1_empty1", 16'(empty), 16'h1);
    chk("t1_usedw0", 16'(usedw), 16'h0);
    chk("t1_unf0", 16'(underflow), 16'h0);

    // 2: overflow drops the write
    fill4();
    step(1'b1, 1'b0, 8'h55, 1'b0);
    chk("t2_ovf", 16'(overflow), 16'h1);
    chk("t2_usedw", 16'(usedw), 16'h4);
    chk("t2_full", 16'(full), 16'h1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t2_q11", 16'(q), 16'h11);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t2_q22", 16'(q), 16'h22);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t2_q33", 16'(q), 16'h33);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t2_q44", 16'(q), 16'h44);
    chk("t2_empty", 16'(empty), 16'h1);

    // 3: simultaneous read+write while full, with pointer wrap
    fill4();
    step(1'b1, 1'b1, 8'h66, 1'b0);
    chk("t3_q11", 16'(q), 16'h11);
    chk("t3_usedw", 16'(usedw), 16'h4);
    chk("t3_full", 16'(full), 16'h1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t3_q22", 16'(q), 16'h22);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t3_q33", 16'(q), 16'h33);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t3_q44", 16'(q), 16'h44);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t3_q66", 16'(q), 16'h66);
    chk("t3_empty", 16'(empty), 16'h1);

    // 4: simultaneous read+write while empty
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("t4_unf", 16'(underflow), 16'h1);
    chk("t4_usedw", 16'(usedw), 16'h1);
    chk("t4_empty", 16'(empty), 16'h0);
    chk("t4_q_hold", 16'(q), 16'h66);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t4_q77", 16'(q), 16'h77);
    chk("t4_usedw0", 16'(usedw), 16'h0);

    // 5: clear beats a same-cycle write
    step(1'b1, 1'b0, 8'h81, 1'b0);
    step(1'b1, 1'b0, 8'h82, 1'b0);
    step(1'b1, 1'b0, 8'h83, 1'b0);
    chk("t5_usedw3", 16'(usedw), 16'h3);
    chk("t5_ovf_sticky", 16'(overflow), 16'h1);
    step(1'b1, 1'b0, 8'h88, 1'b1);
    chk("t5_usedw0", 16'(usedw), 16'h0);
    chk("t5_empty", 16'(empty), 16'h1);
    chk("t5_full", 16'(full), 16'h0);
    chk("t5_ovf0", 16'(overflow), 16'h0);
    chk("t5_unf0", 16'(underflow), 16'h0);
    chk("t5_q_hold", 16'(q), 16'h77);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t5_rd_empty_unf", 16'(underflow), 16'h1);
    chk("t5_rd_empty_q", 16'(q), 16'h77);
    step(1'b1, 1'b0, 8'h99, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t5_post_clear_q", 16'(q), 16'h99);

    // 6: asynchronous reset between edges
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    chk("t6_q_pre", 16'(q), 16'hA5);
    chk("t6_usedw_pre", 16'(usedw), 16'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_q", 16'(q), 16'h00);
    chk("t6_empty", 16'(empty), 16'h1);
    chk("t6_usedw", 16'(usedw), 16'h0);
    chk("t6_unf", 16'(underflow), 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t6_after_q", 16'(q), 16'h3C);
    chk("t6_after_empty", 16'(empty), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
